// File: rtl/mulh_pkg.sv
// Shared encodings for the multi-cycle RV32M multiply sequencer.
package mulh_pkg;

   typedef enum logic [1:0] {
      MUL_OP_MUL    = 2'b00,
      MUL_OP_MULH   = 2'b01,
      MUL_OP_MULHSU = 2'b10,
      MUL_OP_MULHU  = 2'b11
   } mul_op_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL  = 3'd1,
      WAIT = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } mul_state_e;

   // Left shift applied to each partial product before accumulation.
   // idx 0: lo*lo, idx 1: hiA*loB, idx 2: loA*hiB, idx 3: hi*hi.
   function automatic logic [5:0] pp_shift(input logic [1:0] idx);
      case (idx)
         2'd0:    pp_shift = 6'd0;
         2'd1:    pp_shift = 6'd16;
         2'd2:    pp_shift = 6'd16;
         default: pp_shift = 6'd32;
      endcase
   endfunction

endpackage

// File: rtl/mul16x16_unit.sv
// Unsigned 16x16->32 multiplier with optional output register.
module mul16x16_unit #(
   parameter int MUL_PIPE = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] p
);

   logic [31:0] prod_p0;
   logic [31:0] prod_p1;

   assign prod_p0 = {16'b0, a} * {16'b0, b};

   // Output register; only observed when MUL_PIPE=1, trimmed otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prod_p1 <= '0;
      else     prod_p1 <= prod_p0;
   end

   assign p = (MUL_PIPE == 0) ? prod_p0 : prod_p1;

endmodule

// File: rtl/mulh_sequencer.sv
// Sequences four 16x16 partial products through one shared multiplier and
// applies signed correction to produce MUL/MULH/MULHSU/MULHU results.
module mulh_sequencer
   import mulh_pkg::*;
#(
   parameter int MUL_PIPE = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic        flush,
   output logic        ready,
   output logic        busy,
   output logic        result_valid,
   input  logic        result_ready,
   output logic [31:0] result
);

   mul_state_e  state;
   mul_op_e     op_r;
   logic [1:0]  idx;
   logic [63:0] acc;
   logic [63:0] acc_next;
   logic [31:0] a_r;
   logic [31:0] b_r;
   logic [15:0] mul_a;
   logic [15:0] mul_b;
   logic [31:0] prod;

   // Signed correction of the unsigned high word, modulo 2^32.
   function automatic logic [31:0] fix_hi(input mul_op_e op_f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi);
      logic [31:0] h;
      h = hi;
      if ((op_f == MUL_OP_MULH || op_f == MUL_OP_MULHSU) && a[31]) h = h - b;
      if (op_f == MUL_OP_MULH && b[31]) h = h - a;
      return h;
   endfunction

   assign mul_a    = idx[0] ? a_r[31:16] : a_r[15:0];
   assign mul_b    = idx[1] ? b_r[31:16] : b_r[15:0];
   assign acc_next = acc + ({32'b0, prod} << pp_shift(idx));

   mul16x16_unit #(.MUL_PIPE(MUL_PIPE)) u_mul (
      .clk (clk),
      .rst (rst),
      .a   (mul_a),
      .b   (mul_b),
      .p   (prod)
   );

   // Control FSM with registered handshake outputs and datapath state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         ready        <= 1'b1;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         result       <= '0;
         acc          <= '0;
         idx          <= '0;
         a_r          <= '0;
         b_r          <= '0;
         op_r         <= MUL_OP_MUL;
      end else if (state == IDLE) begin
         // flush in IDLE blocks acceptance
         if (start && !flush) begin
            a_r   <= rs1;
            b_r   <= rs2;
            op_r  <= mul_op_e'(op);
            acc   <= '0;
            idx   <= '0;
            state <= MUL;
            ready <= 1'b0;
            busy  <= 1'b1;
         end
      end else if (flush) begin
         // Pipeline kill: drop the operation, keep the last delivered result.
         state        <= IDLE;
         ready        <= 1'b1;
         busy         <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         case (state)
            MUL: begin
               if (MUL_PIPE == 0) begin
                  acc   <= acc_next;
                  idx   <= idx + 2'd1;
                  state <= (idx == 2'd3) ? FIX : MUL;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               acc   <= acc_next;
               idx   <= idx + 2'd1;
               state <= (idx == 2'd3) ? FIX : MUL;
            end
            FIX: begin
               result       <= (op_r == MUL_OP_MUL) ? acc[31:0]
                                                    : fix_hi(op_r, a_r, b_r, acc[63:32]);
               busy         <= 1'b0;
               result_valid <= 1'b1;
               state        <= DONE;
            end
            DONE: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  ready        <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mulh_sequencer.md
Name: mulh_sequencer

Overview:
- Multi-cycle controller computing RV32M MUL/MULH/MULHSU/MULHU results through one shared unsigned 16x16 multiplier.
- Splits each operand into 16-bit halves, issues four partial products in sequence, accumulates a 64-bit sum, then applies signed correction.
- Sits in the sail-core execute stage beside the ALU. It presents a valid/ready handshake to the pipeline so a single DSP tile serves all multiply-family instructions.

Parameters:
- MUL_PIPE, 0, multiplier unit output latency in cycles (0 = combinational, 1 = registered output); only 0 and 1 are legal.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted on an edge where start=1 and ready=1
- op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- rs1  input  32  operand A (signed for MULH/MULHSU)
- rs2  input  32  operand B (signed for MULH only)
- flush  input  1  abort current operation (pipeline kill)
- ready  output  1  1 only in IDLE
- busy  output  1  1 in MUL, WAIT or FIX
- result_valid  output  1  1 in DONE
- result_ready  input  1  consumer accepts result
- result  output  32  low word for MUL, high word otherwise

Behaviour:
- Reset: state=IDLE, ready=1, busy=0, result_valid=0, result=0, accumulator=0, idx=0. All are applied asynchronously.
- Accept edge: latch rs1, rs2 and op. Clear the 64-bit accumulator, set idx=0, go to MUL. Inputs are ignored in every state except IDLE.
- Partial product order, idx 0..3:
  - idx 0: A[15:0]*B[15:0], shift 0
  - idx 1: A[31:16]*B[15:0], shift 16
  - idx 2: A[15:0]*B[31:16], shift 16
  - idx 3: A[31:16]*B[31:16], shift 32
- MUL state: drive multiplier operands for the current idx.
  - MUL_PIPE=0: at the edge, acc += zero-extended product << shift, then idx++.
  - MUL_PIPE=1: go to WAIT for one cycle with operands held; accumulate at the WAIT edge.
  - After idx=3 is accumulated, go to FIX.
- FIX state (one cycle), operating on the high word hi=acc[63:32], modulo 2^32:
  - If op is MULH or MULHSU and A[31]=1: hi -= B.
  - If op is MULH and B[31]=1: hi -= A.
  - Register result = (op==MUL) ? acc[31:0] : corrected hi. Go to DONE.
- DONE state: result_valid=1, with result stable until the handshake. On an edge with result_ready=1, go to IDLE and drop result_valid. The result register holds its value after the handshake.
- Latency: the accept edge plus 4*(1+MUL_PIPE)+1 edges until result_valid rises. This is 5 edges when MUL_PIPE=0 and 9 when MUL_PIPE=1.
- Throughput: a new start can be accepted no earlier than the edge after the handshake. start is not honoured in the same cycle as the result handshake.
- flush:
  - In MUL, WAIT, FIX or DONE: the next edge returns to IDLE with result_valid=0. The result register is unchanged and the accumulator is discarded.
  - In IDLE: no effect, and it blocks acceptance (flush has priority over start).
- No sign tracking is needed in the accumulator. The unsigned 64-bit sum cannot overflow for 32x32 operands.
- The multiplier unit is always unsigned. All signedness is handled in FIX.

Decomposition:
- Shared package mulh_pkg:
  - op encodings MUL_OP_MUL/MULH/MULHSU/MULHU
  - state encodings IDLE, MUL, WAIT, FIX, DONE
  - partial-product shift table
- Sub-module mul16x16_unit:
  - unsigned 16x16 to 32 product, with optional output register selected by MUL_PIPE
  - its DSP-tile instance is configured unsigned with 16x16 bypass
  - owns only the arithmetic; sequencing stays in mulh_sequencer

Test Plan:
- MULHU rs1=0xFFFFFFFF rs2=0xFFFFFFFF -> result 0xFFFFFFFE. The same operands with MUL -> 0x00000001. result_valid rises exactly 5 edges after accept (MUL_PIPE=0).
- MULH rs1=0xFFFFFFFF rs2=0x00000002 -> 0xFFFFFFFF. MULH rs1=0x80000000 rs2=0x80000000 -> 0x40000000.
- MULHSU rs1=0xFFFFFFFF rs2=0xFFFFFFFF -> 0xFFFFFFFF. MULHSU rs1=0x00000002 rs2=0x80000000 -> 0x00000001.
- Back-pressure: hold result_ready=0 for 3 cycles in DONE -> result and result_valid remain stable. A start pulsed during busy/DONE is ignored, with ready=0 throughout.
- flush asserted at idx=2 -> IDLE next edge with result_valid=0. The next MUL rs1=3 rs2=5 -> 0x0000000F, with no stale accumulator.
- rst asserted mid-FIX, asynchronous to the clock -> outputs immediately at reset values. Repeat tests 1-3 with MUL_PIPE=1 and check a latency of 9 edges.
